// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;
  localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 q_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] next_rem,
  output logic                 q_bit
);

  logic [DIVISOR_W-1:0] t_low;
  logic [DIVISOR_W-1:0] diff;
  logic                 borrow;

  // t = {rem, q_msb} is DIVISOR_W+1 bits; its top bit set means t >= divisor
  // outright, and the low-bit difference is then still the correct remainder.
  assign t_low          = {rem[DIVISOR_W-2:0], q_msb};
  assign {borrow, diff} = {1'b0, t_low} - {1'b0, divisor};
  assign q_bit          = rem[DIVISOR_W-1] | ~borrow;
  assign next_rem       = q_bit ? diff : t_low;

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider with valid/ready handshakes on both sides.
// Optional early zero-divisor detection: SEQ_DIVIDER_ZERO_CHECK_EN.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  div_state_t            state, state_next;
  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVISOR_W-1:0]  rem_reg;
  logic [DIVISOR_W-1:0]  divisor_reg;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_bit;
  logic [DIVIDEND_W-1:0] q_shifted;
  logic                  zero_div;

  seq_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem      (rem_reg),
    .q_msb    (q_reg[DIVIDEND_W-1]),
    .divisor  (divisor_reg),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  assign q_shifted = {q_reg[DIVIDEND_W-2:0], step_bit};
  assign in_ready  = (state == IDLE) && !reset;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = zero_div ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      q_reg       <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      out_valid   <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg       <= dividend;
            divisor_reg <= divisor;
            rem_reg     <= '0;
            cnt         <= CNT_W'(DIVIDEND_W - 1);
            // Early zero-divisor result matches what the full iteration would give.
            if (zero_div) begin
              quotient  <= '1;
              remainder <= dividend[DIVISOR_W-1:0];
              out_valid <= 1'b1;
            end
          end
        end
        CALC: begin
          q_reg   <= q_shifted;
          rem_reg <= step_rem;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            quotient  <= q_shifted;
            remainder <= step_rem;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      div_by_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      div_by_zero <= zero_div;
    end
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; expectations are hand-computed.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; runs one operation and returns at the falling
  // edge of the first IDLE cycle after the output handshake.
  task automatic do_op(input string name, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] exp_q, input logic [7:0] exp_r,
                       input logic exp_dbz, input int exp_lat, input int stall);
    int wait_n = 0;
    int lat;
    while (!in_ready && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (stall == 0);
    acc_cyc   = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".quotient"}, 32'(quotient), 32'(exp_q));
    check({name, ".remainder"}, 32'(remainder), 32'(exp_r));
    check({name, ".div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      dividend = 16'd9;
      divisor  = 8'd3;
      check({name, ".stall_valid"}, 32'(out_valid), 32'd1);
      check({name, ".stall_ready"}, 32'(in_ready), 32'd0);
      check({name, ".stall_q"}, 32'(quotient), 32'(exp_q));
      check({name, ".stall_r"}, 32'(remainder), 32'(exp_r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, ".idle_out_valid"}, 32'(out_valid), 32'd0);
    check({name, ".idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int t0;
    logic        zc;
    int          z_lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
    zc    = 1'b1;
    z_lat = 1;
`else
    zc    = 1'b0;
    z_lat = 17;
`endif
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.quotient", 32'(quotient), 32'd0);
    check("rst.remainder", 32'(remainder), 32'd0);
    check("rst.div_by_zero", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    #1;
    check("rst.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    do_op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17, 0);
    do_op("dffff_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 17, 0);
    t0 = acc_cyc;
    do_op("d5_200", 16'd5, 8'd200, 16'd0, 8'd5, 1'b0, 17, 0);
    check("back2back.interval", 32'(acc_cyc - t0), 32'd18);
    do_op("d1234_0", 16'h1234, 8'd0, 16'hFFFF, 8'h34, zc, z_lat, 0);
    do_op("d300_17", 16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 17, 5);
    // The ignored pulse must not have started a new operation.
    repeat (3) @(negedge clk);
    check("stall.no_extra_op", 32'(out_valid), 32'd0);
    check("stall.still_idle", 32'(in_ready), 32'd1);

    // Reset during the 8th CALC cycle discards the in-flight operation.
    in_valid = 1'b1;
    dividend = 16'd50000;
    divisor  = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset.in_ready_high", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("midreset.out_valid", 32'(out_valid), 32'd0);
    check("midreset.quotient", 32'(quotient), 32'd0);
    check("midreset.remainder", 32'(remainder), 32'd0);
    check("midreset.div_by_zero", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    #1;
    check("midreset.in_ready_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    do_op("d50000_200", 16'd50000, 8'd200, 16'd250, 8'd0, 1'b0, 17, 0);

    do_op("dffff_ff", 16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0, 17, 0);
    do_op("dfffe_ff", 16'hFFFE, 8'hFF, 16'd256, 8'd254, 1'b0, 17, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
